// File: rtl/pipelined_cla_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adder_pkg
// Purpose : Shared constants, flag bundle and geometry check for the
//           pipelined carry-lookahead adder/subtractor.
// Revision: 1.0 - initial release
// ============================================================================
package adder_pkg;

  localparam int c_default_width = 32;
  localparam int c_default_block = 8;

  // Status flags that travel with the final-stage result
  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  // Returns 1 when WIDTH splits evenly into BLOCK-bit groups, else 0.
  // The top divides by this value, so a bad geometry stops elaboration.
  function automatic int geometry_guard(input int width, input int block);
    return ((block > 0) && (width >= block) && ((width % block) == 0)) ? 1 : 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_cla_adder_if.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_cla_adder_if
// Purpose : Operand/result valid-ready stream bundle for the pipelined adder.
//           slave = adder side, master = producer/consumer side.
// Revision: 1.0 - initial release
// ============================================================================
interface pipelined_cla_adder_if #(
  parameter int WIDTH = adder_pkg::c_default_width
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

endinterface
`default_nettype wire

// File: rtl/pipelined_cla_adder_cla_block.sv
`default_nettype none
// ============================================================================
// Module  : cla_block
// Purpose : Combinational BLOCK-bit carry-lookahead adder group. Every carry
//           is a flat sum-of-products of generate/propagate terms and cin,
//           so depth grows with BLOCK, not with a ripple chain.
// Revision: 1.0 - initial release
// ============================================================================
module cla_block
  import adder_pkg::*;
#(
  parameter int BLOCK = c_default_block
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [BLOCK-1:0] w_g;
  logic [BLOCK-1:0] w_p;
  logic [BLOCK:0]   w_gen;
  logic [BLOCK:0]   w_c;

  assign w_g   = a & b;
  assign w_p   = a ^ b;
  // Position 0 is the group carry-in, position s+1 is generate of bit s
  assign w_gen = {w_g, cin};

  // Carry i = OR over sources s<=i of (gen[s] AND every propagate from s to i-1)
  always_comb begin
    logic w_term;
    logic w_acc;
    w_c    = '0;
    w_term = 1'b0;
    w_acc  = 1'b0;
    for (int i = 0; i <= BLOCK; i++) begin
      w_acc = 1'b0;
      for (int s = 0; s <= i; s++) begin
        w_term = w_gen[s];
        for (int m = s; m < i; m++) begin
          w_term = w_term & w_p[m];
        end
        w_acc = w_acc | w_term;
      end
      w_c[i] = w_acc;
    end
  end

  assign sum  = w_p ^ w_c[BLOCK-1:0];
  assign cout = w_c[BLOCK];
  assign cmsb = w_c[BLOCK-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_cla_adder
// Purpose : Pipelined carry-lookahead adder/subtractor. One BLOCK-bit group
//           is resolved per stage; the group carry is registered into the
//           next stage. Upper operand groups are skewed down the pipe and
//           finished lower sum groups ride alongside so the whole result
//           leaves together. Valid/ready stream with whole-pipe stall.
// Revision: 1.0 - initial release
// ============================================================================
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int BLOCK = c_default_block
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_cla_adder_if.slave bus
);

  // Division by zero here rejects WIDTH values that are not a multiple of BLOCK
  localparam int c_guard  = 1 / geometry_guard(WIDTH, BLOCK);
  localparam int c_nstage = (WIDTH / BLOCK) * c_guard;

  // Stage inputs (operands, carry, lower sum so far) and stage results
  logic [WIDTH-1:0] w_a        [c_nstage];
  logic [WIDTH-1:0] w_b        [c_nstage];
  logic             w_cin      [c_nstage];
  logic [WIDTH-1:0] w_sum_in   [c_nstage];
  logic [WIDTH-1:0] w_sum_out  [c_nstage];
  logic [BLOCK-1:0] w_blk_sum  [c_nstage];
  logic             w_blk_cout [c_nstage];
  logic             w_blk_cmsb [c_nstage];

  logic                w_advance;
  flags_t              w_flags;

  // Stage registers; the last element of each is the visible output beat
  logic [c_nstage-1:0] r_valid;
  logic [WIDTH-1:0]    r_sum [c_nstage];
  flags_t              r_flags;

  // Whole pipeline moves unless a finished beat is waiting on the consumer
  assign w_advance = ~r_valid[c_nstage-1] | bus.out_ready;

  // Operand/carry skew registers exist only when there is more than one stage
  if (c_nstage > 1) begin : g_inner
    logic [WIDTH-1:0] r_a [c_nstage-1];
    logic [WIDTH-1:0] r_b [c_nstage-1];
    logic             r_c [c_nstage-1];

    // Carry operands and the group carry from stage k into stage k+1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < c_nstage - 1; k++) begin
          r_a[k] <= '0;
          r_b[k] <= '0;
          r_c[k] <= 1'b0;
        end
      end else if (w_advance) begin
        for (int k = 0; k < c_nstage - 1; k++) begin
          r_a[k] <= w_a[k];
          r_b[k] <= w_b[k];
          r_c[k] <= w_blk_cout[k];
        end
      end
    end
  end

  for (genvar k = 0; k < c_nstage; k++) begin : g_stage
    // Bit positions owned by this stage within the full-width word
    localparam logic [WIDTH-1:0] c_slot = WIDTH'({BLOCK{1'b1}}) << (k * BLOCK);

    if (k == 0) begin : g_head
      // Subtraction is A + ~B + 1; cin only matters in add mode
      assign w_a[k]      = bus.in_a;
      assign w_b[k]      = bus.in_sub ? ~bus.in_b : bus.in_b;
      assign w_cin[k]    = bus.in_sub | bus.in_cin;
      assign w_sum_in[k] = '0;
    end else begin : g_body
      assign w_a[k]      = g_inner.r_a[k-1];
      assign w_b[k]      = g_inner.r_b[k-1];
      assign w_cin[k]    = g_inner.r_c[k-1];
      assign w_sum_in[k] = r_sum[k-1];
    end

    cla_block #(
      .BLOCK (BLOCK)
    ) u_cla (
      .a    (w_a[k][k*BLOCK +: BLOCK]),
      .b    (w_b[k][k*BLOCK +: BLOCK]),
      .cin  (w_cin[k]),
      .sum  (w_blk_sum[k]),
      .cout (w_blk_cout[k]),
      .cmsb (w_blk_cmsb[k])
    );

    // Merge this stage's sum group into the partial result
    assign w_sum_out[k] = (w_sum_in[k] & ~c_slot) |
                          (WIDTH'(w_blk_sum[k]) << (k * BLOCK));
  end

  // Flags come from the top group: overflow is carry-in vs carry-out of the MSB
  assign w_flags = {w_blk_cout[c_nstage-1],
                    w_blk_cmsb[c_nstage-1] ^ w_blk_cout[c_nstage-1],
                    ~|w_sum_out[c_nstage-1]};

  // Valid bits, partial sums and final flags shift together on advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_flags <= '0;
      for (int k = 0; k < c_nstage; k++) begin
        r_sum[k] <= '0;
      end
    end else if (w_advance) begin
      r_valid[0] <= bus.in_valid;
      for (int k = 1; k < c_nstage; k++) begin
        r_valid[k] <= r_valid[k-1];
      end
      for (int k = 0; k < c_nstage; k++) begin
        r_sum[k] <= w_sum_out[k];
      end
      r_flags <= w_flags;
    end
  end

  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_valid[c_nstage-1];
  assign bus.out_sum   = r_sum[c_nstage-1];
  assign bus.out_cout  = r_flags.cout;
  assign bus.out_ovf   = r_flags.ovf;
  assign bus.out_zero  = r_flags.zero;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipelined_cla_adder
// Purpose : Self-checking bench for pipelined_cla_adder (32/8 and 8/8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipelined_cla_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(32)) bus32 ();
  pipelined_cla_adder_if #(.WIDTH(8))  bus8  ();

  pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  pipelined_cla_adder #(.WIDTH(8), .BLOCK(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  // Reference: plain modular arithmetic plus the signed-overflow sign rule
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    logic [63:0] mask, av, be, full;
    res_t r;
    mask   = (64'd1 << w) - 64'd1;
    av     = {32'd0, a} & mask;
    be     = sub ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
    full   = av + be + (sub ? 64'd1 : {63'd0, cin});
    r.sum  = full[31:0] & mask[31:0];
    r.cout = full[w];
    r.ovf  = (av[w-1] == be[w-1]) && (r.sum[w-1] != av[w-1]);
    r.zero = (r.sum == 32'd0);
    return r;
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return m;
      2:       return 32'd1 << (w - 1);
      default: return $urandom & m;
    endcase
  endfunction

  function automatic obs_t observe(input bit sel);
    obs_t o;
    if (sel) begin
      o.valid = bus8.out_valid;  o.ready = bus8.in_ready;
      o.sum   = {24'd0, bus8.out_sum};
      o.cout  = bus8.out_cout;   o.ovf = bus8.out_ovf;  o.zero = bus8.out_zero;
    end else begin
      o.valid = bus32.out_valid; o.ready = bus32.in_ready;
      o.sum   = bus32.out_sum;
      o.cout  = bus32.out_cout;  o.ovf = bus32.out_ovf; o.zero = bus32.out_zero;
    end
    return o;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input logic rdy);
    if (sel) begin
      bus8.in_valid = v;  bus8.in_a = a[7:0];  bus8.in_b = b[7:0];
      bus8.in_cin = cin;  bus8.in_sub = sub;   bus8.out_ready = rdy;
    end else begin
      bus32.in_valid = v; bus32.in_a = a;      bus32.in_b = b;
      bus32.in_cin = cin; bus32.in_sub = sub;  bus32.out_ready = rdy;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input obs_t o, input res_t e);
    check({tag, ".sum"},  o.sum,  e.sum);
    check({tag, ".cout"}, o.cout, e.cout);
    check({tag, ".ovf"},  o.ovf,  e.ovf);
    check({tag, ".zero"}, o.zero, e.zero);
  endtask

  // One beat into an idle pipe; measures latency and checks the result
  task automatic single(input bit sel, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input res_t e,
                        input int exp_lat, input string tag);
    obs_t o;
    int   lat;
    drive(sel, 1'b1, a, b, cin, sub, 1'b1);
    o = observe(sel);
    check({tag, ".in_ready"}, o.ready, 1'b1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    lat = 1;
    o   = observe(sel);
    while (!o.valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      o = observe(sel);
    end
    check({tag, ".latency"}, lat, exp_lat);
    check_res(tag, o, e);
    @(posedge clk); #1;
    o = observe(sel);
    check({tag, ".drained"}, o.valid, 1'b0);
  endtask

  // Streams nbeats through the DUT. Directed mode: in_valid held high and
  // out_ready dropped for 3 cycles after the first result. Random mode:
  // random in_valid gaps and random out_ready.
  task automatic stream(input bit sel, input int nbeats, input bit rand_mode, input string tag);
    res_t        q[$];
    obs_t        o;
    int          w, sent, recv, cyc, stall_left;
    bit          have, seen;
    logic [31:0] a, b;
    logic        cin, sub, v, rdy;
    w = sel ? 8 : 32;
    sent = 0; recv = 0; cyc = 0; stall_left = 0; have = 0; seen = 0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    while ((sent < nbeats || recv < nbeats) && cyc < nbeats * 10 + 100) begin
      if (sent < nbeats && !have) begin
        a = pick(w); b = pick(w);
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        have = 1;
      end
      v = have && (rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
      o = observe(sel);
      if (!rand_mode && o.valid && !seen) begin
        seen = 1;
        stall_left = 3;
      end
      rdy = rand_mode ? ($urandom_range(0, 2) != 0) : (stall_left == 0);
      if (stall_left > 0) stall_left--;
      drive(sel, v, a, b, cin, sub, rdy);
      #1;
      o = observe(sel);
      check({tag, ".in_ready"}, o.ready, (!o.valid || rdy));
      if (o.valid) begin
        if (q.size() == 0) begin
          check({tag, ".spurious_valid"}, o.valid, 1'b0);
        end else begin
          check_res(tag, o, q[0]);
          if (rdy) begin
            void'(q.pop_front());
            recv++;
          end
        end
      end
      if (v && o.ready) begin
        q.push_back(model(w, a, b, cin, sub));
        sent++;
        have = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    drive(sel, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check({tag, ".sent"},     sent, nbeats);
    check({tag, ".received"}, recv, nbeats);
    repeat (3) begin
      o = observe(sel);
      check({tag, ".extra_beat"}, o.valid, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    obs_t        o;
    logic [31:0] ra, rb;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // Reset state
    #12;
    o = observe(1'b0);
    check("reset.out_valid", o.valid, 1'b0);
    check_res("reset", o, res_t'{sum: 32'd0, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
    o = observe(1'b1);
    check("reset8.out_valid", o.valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    o = observe(1'b0);
    check("reset.in_ready", o.ready, 1'b1);

    // Directed corner cases, 32/8
    single(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
           res_t'{sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1}, 4, "add_wrap");
    single(1'b0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0,
           res_t'{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0}, 4, "add_ovf");
    single(1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
           res_t'{sum: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0}, 4, "sub_ovf");
    single(1'b0, 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1,
           res_t'{sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1}, 4, "sub_zero");

    // Back-to-back stream with a 3-cycle consumer stall
    stream(1'b0, 6, 1'b0, "stall6");

    // Reset with three beats in flight (oldest already presented)
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h1234_5678 + i, 32'h0000_0101, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    o = observe(1'b0);
    check("rst_mid.preload_valid", o.valid, 1'b1);
    rst = 1'b1;
    #1;
    o = observe(1'b0);
    check("rst_mid.out_valid", o.valid, 1'b0);
    check_res("rst_mid", o, res_t'{sum: 32'd0, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      o = observe(1'b0);
      check("rst_mid.stale", o.valid, 1'b0);
    end
    ra = $urandom; rb = $urandom;
    single(1'b0, ra, rb, 1'b0, 1'b1, model(32, ra, rb, 1'b0, 1'b1), 4, "post_rst");

    // Random traffic, 32/8
    stream(1'b0, 400, 1'b1, "rand32");

    // Single-stage configuration
    single(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
           res_t'{sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1}, 1, "add8_wrap");
    stream(1'b1, 10000, 1'b1, "rand8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
